// File: rtl/cmd_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : cmd_mem_pkg
// Brief  : Shared state encodings, default widths and words-per-command math
//          for the command memory loader.
// Rev    : 1.0
// ============================================================================
package cmd_mem_pkg;

   localparam int DEF_CMD_WIDTH  = 128;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   function automatic int calc_wpc(input int cmd_w, input int word_w);
      return cmd_w / word_w;
   endfunction

   // Keep the word index at least one bit wide even when WPC is 1.
   function automatic int calc_idx_w(input int wpc);
      return (wpc > 1) ? $clog2(wpc) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module : cmd_mem_loader_if
// Brief  : Word stream handshake plus command memory write port.
// Rev    : 1.0
// ============================================================================
interface cmd_mem_loader_if #(
   parameter int CMD_WIDTH  = 128,
   parameter int ADDR_WIDTH = 8,
   parameter int WORD_WIDTH = 32
);
   logic [WORD_WIDTH-1:0] word_in;
   logic                  word_valid;
   logic                  word_ready;
   logic                  write_enable;
   logic [ADDR_WIDTH-1:0] write_address;
   logic [CMD_WIDTH-1:0]  cmd_in;

   modport master (
      input  word_in, word_valid,
      output word_ready, write_enable, write_address, cmd_in
   );

   modport slave (
      output word_in, word_valid,
      input  word_ready, write_enable, write_address, cmd_in
   );
endinterface
`default_nettype wire

// File: rtl/cmd_mem_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module : cmd_word_packer
// Brief  : Collects WPC narrow words into one command, first word in the LSBs.
// Rev    : 1.0
// ============================================================================
module cmd_word_packer
   import cmd_mem_pkg::*;
#(
   parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
   parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
   input  wire logic                  clk,
   input  wire logic                  rstn,
   input  wire logic                  clear,
   input  wire logic                  accept,
   input  wire logic [WORD_WIDTH-1:0] word_in,
   output logic      [CMD_WIDTH-1:0]  cmd_out,
   output logic                       last
);
   localparam int WPC   = calc_wpc(CMD_WIDTH, WORD_WIDTH);
   localparam int IDX_W = calc_idx_w(WPC);
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WPC - 1);

   logic [IDX_W-1:0]     r_idx;
   logic [CMD_WIDTH-1:0] r_data;
   logic                 w_at_last;

   assign w_at_last = (r_idx == C_LAST_IDX);
   assign last      = accept & w_at_last;

   // Packed view includes the word on the bus so the write can issue next edge.
   always_comb begin
      cmd_out = r_data;
      cmd_out[r_idx*WORD_WIDTH +: WORD_WIDTH] = word_in;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_idx  <= '0;
         r_data <= '0;
      end else if (clear) begin
         r_idx  <= '0;
      end else if (accept) begin
         r_data[r_idx*WORD_WIDTH +: WORD_WIDTH] <= word_in;
         r_idx <= w_at_last ? '0 : r_idx + IDX_W'(1);
      end
   end
endmodule
`default_nettype wire

// File: rtl/cmd_mem_loader.sv
`default_nettype none
// ============================================================================
// Module : cmd_mem_loader
// Brief  : Packs a word stream into commands and writes them to consecutive
//          command memory addresses. Optional CMD_MEM_LOADER_CHECKSUM_EN
//          enables the XOR checksum of written commands.
// Rev    : 1.0
// ============================================================================
module cmd_mem_loader
   import cmd_mem_pkg::*;
#(
   parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
   input  wire logic                  clk,
   input  wire logic                  rstn,
   input  wire logic                  start,
   input  wire logic [ADDR_WIDTH-1:0] start_addr,
   input  wire logic [ADDR_WIDTH:0]   cmd_count,
   input  wire logic                  abort,
   output logic                       busy,
   output logic                       done,
   output logic      [CMD_WIDTH-1:0]  checksum,
   cmd_mem_loader_if.master           bus
);
   state_t                r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH:0]   r_remaining;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [CMD_WIDTH-1:0]  r_cmd;
   logic [CMD_WIDTH-1:0]  w_packed;
   logic                  w_accept, w_last, w_start_ok, w_clear, w_commit;

   assign w_accept   = bus.word_valid & (r_state == ST_FILL);
   assign w_start_ok = (r_state == ST_IDLE) & start;
   assign w_clear    = w_start_ok | ((r_state == ST_FILL) & abort);
   // Abort beats a last-word handshake in the same cycle: the command is dropped.
   assign w_commit   = (r_state == ST_FILL) & w_last & ~abort;

   cmd_word_packer #(
      .CMD_WIDTH  (CMD_WIDTH),
      .WORD_WIDTH (WORD_WIDTH)
   ) u_packer (
      .clk     (clk),
      .rstn    (rstn),
      .clear   (w_clear),
      .accept  (w_accept),
      .word_in (bus.word_in),
      .cmd_out (w_packed),
      .last    (w_last)
   );

   always_ff @(posedge clk) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = (cmd_count == '0) ? ST_FINISH : ST_FILL;
         end
         ST_FILL: begin
            busy = 1'b1;
            if (abort)                                 w_next = ST_FINISH;
            else if (w_last && r_remaining == (ADDR_WIDTH+1)'(1)) w_next = ST_FINISH;
         end
         ST_FINISH: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_addr      <= '0;
         r_remaining <= '0;
         r_we        <= 1'b0;
         r_waddr     <= '0;
         r_cmd       <= '0;
      end else begin
         r_we <= 1'b0;
         if (w_start_ok) begin
            r_addr      <= start_addr;
            r_remaining <= cmd_count;
         end else if (w_commit) begin
            r_we        <= 1'b1;
            r_waddr     <= r_addr;
            r_cmd       <= w_packed;
            r_addr      <= r_addr + ADDR_WIDTH'(1);
            r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
         end
      end
   end

   assign bus.word_ready    = (r_state == ST_FILL);
   assign bus.write_enable  = r_we;
   assign bus.write_address = r_waddr;
   assign bus.cmd_in        = r_cmd;

`ifdef CMD_MEM_LOADER_CHECKSUM_EN
   logic [CMD_WIDTH-1:0] r_checksum;

   always_ff @(posedge clk) begin
      if (!rstn)          r_checksum <= '0;
      else if (w_start_ok) r_checksum <= '0;
      else if (w_commit)  r_checksum <= r_checksum ^ w_packed;
   end

   assign checksum = r_checksum;
`else
   assign checksum = '0;
`endif
endmodule
`default_nettype wire

// File: doc/cmd_mem_loader.md
# cmd_mem_loader

Writer side of the command memory: accepts a stream of narrow bus words over a valid/ready handshake, packs each group of CMD_WIDTH/WORD_WIDTH words into one command, and drives the memory write port (write_enable, write_address, cmd_in) at consecutive addresses from a programmed start address. It sits between the host/DMA word stream and the per-core command memory, which is read by the processor fetch path with one-cycle read latency.

## Interface
- CMD_WIDTH, 128, command width; must equal the memory command width.
- ADDR_WIDTH, 8, memory address width; depth is 2**ADDR_WIDTH.
- WORD_WIDTH, 32, input word width; CMD_WIDTH must be an integer multiple (WPC = CMD_WIDTH/WORD_WIDTH ≥ 1).
- clk  in  1  system clock; all logic on posedge.
- rstn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin a load; ignored while busy.
- start_addr  in  ADDR_WIDTH  first write address, sampled on accepted start.
- cmd_count  in  ADDR_WIDTH+1  number of commands to load, sampled on accepted start; 0 is legal.
- abort  in  1  cancels the load in progress.
- word_in  in  WORD_WIDTH  stream data.
- word_valid  in  1  stream data valid.
- word_ready  out  1  loader accepts word_in this cycle.
- write_enable  out  1  one-cycle memory write strobe.
- write_address  out  ADDR_WIDTH  memory write address.
- cmd_in  out  CMD_WIDTH  packed command to memory.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at load completion (normal or abort).
- checksum  out  CMD_WIDTH  XOR of all commands written in the current/last load.

## Operation
- States: IDLE, FILL, FINISH.
- IDLE: word_ready=0, busy=0. start=1 → latch start_addr into address counter, cmd_count into remaining counter, clear word index and checksum; go FILL if cmd_count≠0, else FINISH.
- FILL: busy=1, word_ready=1. Each handshake (word_valid & word_ready) stores word_in into slice [k*WORD_WIDTH +: WORD_WIDTH], k = word index 0..WPC-1 (first word = LSBs); index increments.
- On handshake with k=WPC-1: next cycle write_enable=1, cmd_in = assembled command, write_address = current address; address increments modulo 2**ADDR_WIDTH (wraps 255→0 at default); remaining decrements; index → 0. No bubble: word_ready stays 1, next command's first word may be accepted in the same cycle write_enable is high.
- When the final command's last word is accepted: word_ready drops next cycle, go FINISH.
- FINISH: one cycle; done=1, busy=0 next → IDLE.
- abort in FILL: partial command discarded, no further writes (a write already scheduled for this cycle completes), → FINISH. abort in IDLE ignored; abort and start in the same IDLE cycle: start wins.
- start while busy: ignored, no effect on latched values.
- cmd_count > 2**ADDR_WIDTH: load proceeds, address wraps, earlier entries overwritten.
- word_valid without word_ready: word not consumed, no state change.

## Timing
- Reset (rstn=0 at posedge): state IDLE; word_ready, write_enable, busy, done = 0; write_address, cmd_in, checksum = 0; partial command discarded, no write issued. Applies mid-load identically.
- start at edge N → word_ready=1, busy=1 from cycle N+1.
- Last word of a command accepted at edge M → write_enable=1 during cycle M+1 only.
- Final command: write_enable in cycle M+1, done in cycle M+1 as well (FINISH entered at edge M); busy=0 in cycle M+1.
- cmd_count=0: done in cycle N+1, no write_enable ever.
- Full-rate load of C commands takes C*WPC cycles of stream plus 1 cycle write latency.

## Configuration
- CMD_MEM_LOADER_CHECKSUM_EN defined: checksum register XORs cmd_in on every write_enable; cleared on accepted start and reset; holds value after done until next start.
- Not defined: checksum tied to 0, no register inferred.

## Structure
- Shared package cmd_mem_pkg: state encodings (IDLE/FILL/FINISH), default CMD_WIDTH/ADDR_WIDTH/WORD_WIDTH constants, WPC derivation.
- One sub-module: cmd_word_packer (word index counter + slice-write shift register, emits packed command and last-word flag).

## Test plan
- start_addr=0x10, cmd_count=2, 8 words 0x0..0x7 at full rate → writes at 0x10 = 0x00000003_00000002_00000001_00000000, 0x11 = 0x...07_06_05_04; done one pulse, aligned with the second write.
- start_addr=0xFF, cmd_count=2 → write addresses 0xFF then 0x00.
- cmd_count=0 → done in cycle after start, write_enable never asserted.
- word_valid toggled 1/0 every cycle, cmd_count=1 → single write with correct data after 4th accepted word; no spurious writes.
- abort after 6 of 8 words (cmd_count=2) → exactly one write (first command), done pulse, return to IDLE; start during busy ignored.
- rstn=0 after 2 words → all outputs 0, no write; with CMD_MEM_LOADER_CHECKSUM_EN, a 2-command load yields checksum = XOR of both commands.
